// File: rtl/arb_resp_pkg.sv
// arb_resp_pkg: shared width helper and FIFO occupancy states for the arbiter response demux.
package arb_resp_pkg;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_resp_idx_fifo.sv
// arb_resp_idx_fifo: no-fall-through index FIFO, any depth >= 1, synchronous reset and flush.
module arb_resp_idx_fifo
    import arb_resp_pkg::*;
#(
    parameter int unsigned Depth    = 4,
    parameter int unsigned Width    = 2,
    parameter int unsigned CntWidth = idx_width(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush,
    input  logic                push,
    input  logic [Width-1:0]    din,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [CntWidth-1:0] cnt,
    output logic [Width-1:0]    head
);

    localparam int unsigned PtrWidth = idx_width(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            cnt <= cnt + CntWidth'(push) - CntWidth'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush) mem[wr_ptr] <= din;
    end

    assign full  = (cnt == CntWidth'(Depth));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/arb_resp_demux.sv
// arb_resp_demux: steers in-order responses back to the requestor recorded at request handshake.
// Define ARB_RESP_DEMUX_ERR_EN to drop and flag responses arriving with nothing outstanding.
module arb_resp_demux
    import arb_resp_pkg::*;
#(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTxns   = 4,
    parameter int unsigned IdxWidth  = idx_width(NumOut),
    parameter int unsigned CntWidth  = idx_width(MaxTxns + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    input  logic [IdxWidth-1:0]  req_idx_i,
    output logic                 req_ready_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic                 rsp_valid_i,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic                 rsp_ready_o,
    output logic [NumOut-1:0]    rsp_valid_o,
    output logic [DataWidth-1:0] rsp_data_o,
    input  logic [NumOut-1:0]    rsp_ready_i,
    output logic [CntWidth-1:0]  cnt_o,
    output logic                 err_o
);

    logic                full, empty, push, pop;
    logic [IdxWidth-1:0] head;
    occ_e                occ;

    arb_resp_idx_fifo #(
        .Depth   (MaxTxns),
        .Width   (IdxWidth),
        .CntWidth(CntWidth)
    ) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush(flush_i),
        .push (push),
        .din  (req_idx_i),
        .pop  (pop),
        .full (full),
        .empty(empty),
        .cnt  (cnt_o),
        .head (head)
    );

    assign req_valid_o = req_valid_i & ~full;
    assign req_ready_o = req_ready_i & ~full;
    assign push        = req_valid_o & req_ready_i;

    assign rsp_data_o  = rsp_data_i;
    assign rsp_valid_o = (empty || !rsp_valid_i) ? '0 : NumOut'(1) << head;
    assign pop         = rsp_valid_i & rsp_ready_o & ~empty;

`ifdef ARB_RESP_DEMUX_ERR_EN
    assign rsp_ready_o = empty ? 1'b1 : rsp_ready_i[head];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) err_o <= 1'b0;
        else if (empty && rsp_valid_i) err_o <= 1'b1;
    end
`else
    assign rsp_ready_o = empty ? 1'b0 : rsp_ready_i[head];
    assign err_o       = 1'b0;
`endif

    assign occ = empty ? EMPTY : (full ? FULL : PARTIAL);

    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i) !(empty && rsp_valid_i))
        else $warning("arb_resp_demux: response arrived with no outstanding transaction");

    c_full: cover property (@(posedge clk_i) occ == FULL);

endmodule
